// File: rtl/sram_mem_controller.sv
// Data-memory sequencer for the MEM stage over a 16-bit asynchronous SRAM.
// Each 32-bit access is split into two half-word phases (low half first);
// ready_o stays low for the whole access so the pipeline freezes.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  input  logic [31:0]            address_i,
  input  logic [31:0]            write_data_i,
  output logic [31:0]            read_data_o,
  output logic                   ready_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [15:0]            sram_dq_out_o,
  output logic                   sram_dq_oe_o,
  input  logic [15:0]            sram_dq_in_i,
  output logic                   sram_we_n_o
);

  localparam int unsigned IdxW     = SRAM_ADDR_W - 1;
  localparam logic [2:0]  WaitLast = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [15:0]            lo_hold_q, lo_hold_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]            dq_out_q, dq_out_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   we_n_q, we_n_d;

  logic        req;
  logic        phase_end;
  logic [31:0] offset;
  logic        unused_offset;

  assign req       = wr_en_i | rd_en_i;
  assign offset    = address_i - BASE_ADDR;
  assign phase_end = (cnt_q == WaitLast);
  // Out-of-range addresses wrap: only the word-index bits that fit are kept.
  assign unused_offset = ^{offset[31:IdxW+2], offset[1:0]};

  // Next-state logic: phase sequencing, operand latching and read capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    lo_hold_d   = lo_hold_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    ready_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Combinational so the freeze lands in the same cycle as the request.
        ready_o = ~req;
        if (req) begin
          state_d     = StLo;
          cnt_d       = 3'd0;
          op_wr_d     = wr_en_i;
          idx_d       = offset[IdxW+1:2];
          wdata_d     = write_data_i;
          sram_addr_d = {offset[IdxW+1:2], 1'b0};
        end
      end
      StLo: begin
        if (phase_end) begin
          state_d     = StHi;
          cnt_d       = 3'd0;
          sram_addr_d = {idx_q, 1'b1};
          if (!op_wr_q) lo_hold_d = sram_dq_in_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StHi: begin
        if (phase_end) begin
          state_d = StDone;
          cnt_d   = 3'd0;
          if (!op_wr_q) read_data_d = {sram_dq_in_i, lo_hold_q};
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        ready_o = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SRAM pin values for the coming cycle, derived from the next state so the
  // pins come straight from flops. The last cycle of a write phase releases
  // we_n to give data/address hold before the address moves.
  always_comb begin
    we_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = 16'h0000;
    if (op_wr_d && (state_d == StLo || state_d == StHi)) begin
      dq_oe_d  = 1'b1;
      dq_out_d = (state_d == StLo) ? wdata_d[15:0] : wdata_d[31:16];
      we_n_d   = ~(cnt_d < WaitLast);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
      lo_hold_q   <= 16'h0;
      read_data_q <= 32'h0;
      sram_addr_q <= '0;
      dq_out_q    <= 16'h0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      lo_hold_q   <= lo_hold_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign read_data_o   = read_data_q;
  assign sram_addr_o   = sram_addr_q;
  assign sram_dq_out_o = dq_out_q;
  assign sram_dq_oe_o  = dq_oe_q;
  assign sram_we_n_o   = we_n_q;

endmodule
